// File: rtl/trdb_pkg.sv
// Shared definitions for the trace packet path (encoder, serializer, bench).
// Contents:
//   PACKET_TOTAL / LEN_W  maximum packet width and width of its length field
//   WORD_W / MAX_WORDS    output word width and words per full packet
//   trdb_packet_t         packet payload plus length
//   trdb_sat_len          clamps an out-of-range length to PACKET_TOTAL
//   trdb_mask             zeroes payload bits at or above the length
//   trdb_word_count       number of output words a length occupies
package trdb_pkg;

  localparam int PACKET_TOTAL = 128;
  localparam int LEN_W        = $clog2(PACKET_TOTAL + 1);
  localparam int WORD_W       = 32;
  localparam int MAX_WORDS    = PACKET_TOTAL / WORD_W;
  localparam int WCNT_W       = $clog2(MAX_WORDS + 1);
  localparam int IDX_W        = $clog2(MAX_WORDS);

  typedef struct packed {
    logic [PACKET_TOTAL-1:0] bits;
    logic [LEN_W-1:0]        len;
  } trdb_packet_t;

  function automatic logic [LEN_W-1:0] trdb_sat_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(PACKET_TOTAL)) return LEN_W'(PACKET_TOTAL);
    return len;
  endfunction

  function automatic logic [PACKET_TOTAL-1:0] trdb_mask(input logic [PACKET_TOTAL-1:0] bits,
                                                       input logic [LEN_W-1:0]        len);
    logic [PACKET_TOTAL-1:0] m;
    for (int i = 0; i < PACKET_TOTAL; i++) m[i] = (i < int'(len));
    return bits & m;
  endfunction

  // ceil(len / WORD_W), computed one bit wider so len = PACKET_TOTAL cannot overflow
  function automatic logic [WCNT_W-1:0] trdb_word_count(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] t;
    t = {1'b0, len} + (LEN_W + 1)'(WORD_W - 1);
    return WCNT_W'(t >> $clog2(WORD_W));
  endfunction

endpackage

// File: rtl/trdb_packet_serializer.sv
// Splits one variable-length trace packet into 32-bit words, LS word first.
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   packet_valid_i/ready_o packet handshake; ready is combinational so a new
//                          packet can be taken during the last-word handshake
//   packet_bits_i/len_i    payload (bit 0 first) and its length in bits
//   word_valid_o/ready_i   word handshake toward the trace sink
//   word_data_o/last_o     current word and last-of-packet flag
//   clear_i                synchronous abort of the packet in flight + counter clear
//   words_sent_o           wrapping count of word handshakes
module trdb_packet_serializer
  import trdb_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    packet_valid_i,
  output logic                    packet_ready_o,
  input  logic [PACKET_TOTAL-1:0] packet_bits_i,
  input  logic [LEN_W-1:0]        packet_len_i,
  output logic                    word_valid_o,
  input  logic                    word_ready_i,
  output logic [WORD_W-1:0]       word_data_o,
  output logic                    word_last_o,
  input  logic                    clear_i,
  output logic [31:0]             words_sent_o
);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t                  state_reg, state_next;
  logic [PACKET_TOTAL-1:0] held_reg, held_next;
  logic [WCNT_W-1:0]       nwords_reg, nwords_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [WORD_W-1:0]       data_reg, data_next;
  logic                    last_reg, last_next;
  logic [31:0]             sent_reg, sent_next;

  logic                    word_hs;
  logic                    accept;
  logic [LEN_W-1:0]        len_sat;
  logic [PACKET_TOTAL-1:0] masked;
  logic [WCNT_W-1:0]       wcount;
  logic [IDX_W-1:0]        idx_inc;

  assign word_valid_o   = (state_reg == ST_SEND);
  assign word_data_o    = data_reg;
  assign word_last_o    = last_reg;
  assign words_sent_o   = sent_reg;

  assign word_hs        = word_valid_o & word_ready_i;
  assign packet_ready_o = ~clear_i & ((state_reg == ST_IDLE) | (word_hs & last_reg));
  assign accept         = packet_valid_i & packet_ready_o;

  assign len_sat        = trdb_sat_len(packet_len_i);
  assign masked         = trdb_mask(packet_bits_i, len_sat);
  assign wcount         = trdb_word_count(len_sat);
  assign idx_inc        = idx_reg + IDX_W'(1);

  // The outgoing word and last flag are precomputed into registers so they
  // change only on an accept or a word handshake and hold during stalls.
  always_comb begin
    state_next  = state_reg;
    held_next   = held_reg;
    nwords_next = nwords_reg;
    idx_next    = idx_reg;
    data_next   = data_reg;
    last_next   = last_reg;
    sent_next   = sent_reg;

    if (clear_i) begin
      state_next  = ST_IDLE;
      held_next   = '0;
      nwords_next = '0;
      idx_next    = '0;
      data_next   = '0;
      last_next   = 1'b0;
      sent_next   = '0;
    end else begin
      if (word_hs) sent_next = sent_reg + 32'd1;

      if (accept && (len_sat != '0)) begin
        state_next  = ST_SEND;
        held_next   = masked;
        nwords_next = wcount;
        idx_next    = '0;
        data_next   = masked[WORD_W-1:0];
        last_next   = (wcount == WCNT_W'(1));
      end else if (accept || (word_hs && last_reg)) begin
        // zero-length packet consumed, or last word gone with nothing new
        state_next  = ST_IDLE;
        idx_next    = '0;
        data_next   = '0;
        last_next   = 1'b0;
      end else if (word_hs) begin
        idx_next    = idx_inc;
        data_next   = held_reg[{idx_inc, 5'b0} +: WORD_W];
        last_next   = ({1'b0, idx_inc} == (nwords_reg - WCNT_W'(1)));
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= ST_IDLE;
      held_reg   <= '0;
      nwords_reg <= '0;
      idx_reg    <= '0;
      data_reg   <= '0;
      last_reg   <= 1'b0;
      sent_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      held_reg   <= held_next;
      nwords_reg <= nwords_next;
      idx_reg    <= idx_next;
      data_reg   <= data_next;
      last_reg   <= last_next;
      sent_reg   <= sent_next;
    end
  end

endmodule

// File: doc/trdb_packet_serializer.md
# trdb_packet_serializer

Downstream consumer of the trace packet encoder: accepts one variable-length trace packet (up to PACKET_TOTAL bits, LSB-aligned) per valid/ready handshake. It emits the packet as a stream of 32-bit words, least-significant word first, with a last-word flag. It sits between the encoder and the word-wide trace sink (FIFO/APB readout). It masks bits above the packet length to zero and never drops data; backpressure propagates upstream.

## Interface
- PACKET_TOTAL, 128, max packet width in bits; multiple of 32.
- LEN_W, $clog2(PACKET_TOTAL+1) = 8, width of the length field.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- packet_valid_i  in  1  packet offered.
- packet_ready_o  out  1  packet accepted when high with packet_valid_i.
- packet_bits_i  in  PACKET_TOTAL  packet payload, bit 0 first.
- packet_len_i  in  LEN_W  payload length in bits, 0..PACKET_TOTAL.
- word_valid_o  out  1  output word valid.
- word_ready_i  in  1  sink accepts word.
- word_data_o  out  32  output word.
- word_last_o  out  1  current word is last of its packet.
- clear_i  in  1  synchronous abort: discard the packet in flight, zero the counter.
- words_sent_o  out  32  count of word handshakes, wraps at 2^32.

## Operation
- States: IDLE (no packet held), SEND (packet held, words pending).
- Acceptance: packet_ready_o = IDLE | (SEND & word_valid_o & word_ready_i & word_last_o). The term from word_ready_i to packet_ready_o is combinational and intentional; it permits back-to-back packets with no bubble.
- On accept with len > 0:
  - Register payload AND mask(len).
  - nwords = ceil(len/32), i.e. (len+31)>>5.
  - idx = 0.
  - Go to SEND.
- On accept with len == 0: the packet is consumed and no words are produced. State is IDLE, or IDLE after the current last word.
- SEND:
  - word_valid_o = 1.
  - word_data_o = held[32*idx +: 32].
  - word_last_o = (idx == nwords-1).
  - On handshake: if not last, idx++. If last, go to IDLE unless a new packet is accepted the same cycle, in which case reload and stay in SEND.
- Output stability: word_data_o and word_last_o are stable while word_valid_o=1 and word_ready_i=0.
- IDLE: word_valid_o = 0; word_data_o and word_last_o = 0.
- words_sent_o increments by 1 per word handshake and wraps 0xFFFFFFFF -> 0.
- clear_i:
  - Forces IDLE, idx=0, and words_sent_o=0 next cycle.
  - packet_ready_o = 0 during clear_i.
  - A word handshake coincident with clear_i is not counted.
- len > PACKET_TOTAL is illegal; it is saturated to PACKET_TOTAL.

## Timing
- Reset values:
  - state = IDLE.
  - packet_ready_o = 1 (IDLE).
  - word_valid_o, word_last_o = 0.
  - word_data_o = 0.
  - words_sent_o = 0.
  - Held payload, idx and nwords = 0.
- Latency: packet accepted at edge N gives its first word valid in the cycle after N. Throughput is 1 word/cycle under no backpressure.
- A 128-bit packet occupies 4 cycles.
- Back-to-back: next packet's word 0 follows its predecessor's last word in the immediately following cycle.
- Reset asserted mid-packet drops the packet immediately and asynchronously. Outputs go to reset values without waiting for a clock edge.
- All outputs except packet_ready_o are registered.

## Structure
- PACKET_TOTAL, the length width and a packet typedef (bits + len) belong in trdb_pkg, shared with the encoder and testbench.
- A small function (mask by length, word count) belongs in trdb_pkg so the testbench scoreboard reuses it.
- No sub-module: a single FSM plus datapath; the expected size is about 150–250 lines.

## Test plan
- Single packet, len=40, bits=0xFFFF_FFFF_FFFF_FFFF... -> two words: 0xFFFFFFFF (last=0), then 0x000000FF (last=1); words_sent_o=2.
- Back-to-back 128-bit packets A, B with word_ready_i=1 -> 8 consecutive valid cycles, no bubble; packet_ready_o high in A's last-word cycle.
- Random word_ready_i stalls during a 96-bit packet -> data/last stable while stalled; 3 words in order; no packet accepted before last handshake.
- len=0 packet, then len=32 packet with value 0x12345678 -> only one word 0x12345678, last=1.
- clear_i asserted while word 1 of a 4-word packet is stalled -> next cycle word_valid_o=0, words_sent_o=0, packet_ready_o=1.
- rst_ni pulsed low mid-packet -> outputs return to reset values immediately; a subsequent 32-bit packet serializes normally.
